// File: rtl/bus_rr_arbiter_pkg.sv
// rtl/bus_rr_arbiter_pkg.sv - shared types for the round-robin bus arbiter
//
// Purpose: state encoding used by bus_rr_arbiter.
//   ST_IDLE : no owner, arbitration runs every cycle
//   ST_BUSY : grant_idx owns the bus until a release condition
package bus_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/decoder.sv
// rtl/decoder.sv - binary index to one-hot decoder
//
// Purpose: turns an inputLen-bit index into a (1 << inputLen)-bit one-hot word.
// Ports:
//   idx    in   inputLen       binary index
//   onehot out  1 << inputLen  bit idx set, all others clear
module decoder #(
  parameter int inputLen = 3
) (
  input  logic [inputLen-1:0]      idx,
  output logic [(1<<inputLen)-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin arbiter for one shared bus/write port
//
// Purpose: grants one of numReq requesters at a time, holding the grant until
// done, a request drop, or the hold limit. Priority after a release starts at
// the requester just above the previous owner.
// Ports:
//   clk          in   1         rising-edge clock
//   reset        in   1         asynchronous active-high reset
//   req          in   numReq    request vector, bit i = requester i
//   done         in   1         owner finished (ignored in IDLE)
//   grant_valid  out  1         a grant is active
//   grant_idx    out  inputLen  current (or last) owner index
//   grant_onehot out  numReq    one-hot owner select, zero when no grant
//   timeout      out  1         one-cycle pulse: grant revoked by hold limit
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter  int inputLen = 3,
  parameter  int maxHold  = 16,
  localparam int numReq   = 1 << inputLen,
  localparam int cntLen   = (maxHold < 1) ? 1 : $clog2(maxHold + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [numReq-1:0]   req,
  input  logic                done,
  output logic                grant_valid,
  output logic [inputLen-1:0] grant_idx,
  output logic [numReq-1:0]   grant_onehot,
  output logic                timeout
);

  // Hold limit constants; with maxHold == 0 the timeout path is disabled and
  // the counter simply sits at zero.
  localparam int unsigned     hold_last_i = (maxHold == 0) ? 0 : maxHold - 1;
  localparam int unsigned     hold_sat_i  = maxHold;
  localparam logic [cntLen-1:0] hold_last = hold_last_i[cntLen-1:0];
  localparam logic [cntLen-1:0] hold_sat  = hold_sat_i[cntLen-1:0];
  localparam bit              timeout_en  = (maxHold != 0);

  arb_state_t          state_q;
  logic [inputLen-1:0] ptr_q;
  logic [cntLen-1:0]   hold_cnt_q;

  arb_state_t          state_nxt;
  logic [inputLen-1:0] ptr_nxt;
  logic [cntLen-1:0]   hold_cnt_nxt;
  logic                valid_nxt;
  logic [inputLen-1:0] idx_nxt;
  logic                timeout_nxt;

  logic                sel_found;
  logic [inputLen-1:0] sel_idx;
  logic                rel_done;
  logic                rel_drop;
  logic                rel_limit;
  logic [numReq-1:0]   dec_onehot;

  // Returns {found, index} of the first set bit of r at or above p, wrapping
  // from numReq-1 back to 0. The scan runs downward so the lowest offset from
  // p is the last to write and therefore wins.
  function automatic logic [inputLen:0] rr_select(
    input logic [numReq-1:0]   r,
    input logic [inputLen-1:0] p
  );
    logic                found;
    logic [inputLen-1:0] sel;
    logic [inputLen-1:0] cand;
    found = 1'b0;
    sel   = '0;
    for (int i = numReq - 1; i >= 0; i--) begin
      cand = p + i[inputLen-1:0];
      if (r[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    return {found, sel};
  endfunction

  always_comb begin
    {sel_found, sel_idx} = rr_select(req, ptr_q);
  end

  assign rel_done  = done;
  assign rel_drop  = ~req[grant_idx];
  assign rel_limit = timeout_en && (hold_cnt_q == hold_last);

  always_comb begin
    state_nxt    = state_q;
    ptr_nxt      = ptr_q;
    hold_cnt_nxt = hold_cnt_q;
    valid_nxt    = grant_valid;
    idx_nxt      = grant_idx;
    timeout_nxt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_nxt = 1'b0;
        if (sel_found) begin
          state_nxt    = ST_BUSY;
          valid_nxt    = 1'b1;
          idx_nxt      = sel_idx;
          hold_cnt_nxt = '0;
        end
      end

      ST_BUSY: begin
        if (rel_done || rel_drop || rel_limit) begin
          // grant_idx is left alone so the last owner stays visible.
          state_nxt    = ST_IDLE;
          valid_nxt    = 1'b0;
          ptr_nxt      = grant_idx + inputLen'(1);
          hold_cnt_nxt = '0;
          timeout_nxt  = rel_limit && !rel_done && !rel_drop;
        end else if (hold_cnt_q != hold_sat) begin
          hold_cnt_nxt = hold_cnt_q + cntLen'(1);
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // Decoding the next owner lets grant_onehot come straight out of a flop,
  // aligned with grant_idx.
  decoder #(
    .inputLen(inputLen)
  ) u_decoder (
    .idx   (idx_nxt),
    .onehot(dec_onehot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      hold_cnt_q   <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      grant_onehot <= '0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      ptr_q        <= ptr_nxt;
      hold_cnt_q   <= hold_cnt_nxt;
      grant_valid  <= valid_nxt;
      grant_idx    <= idx_nxt;
      grant_onehot <= valid_nxt ? dec_onehot : '0;
      timeout      <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - scoreboard bench for bus_rr_arbiter
module tb_bus_rr_arbiter;

  localparam int inputLen = 3;
  localparam int maxHold  = 16;
  localparam int numReq   = 1 << inputLen;

  logic                clk;
  logic                reset;
  logic [numReq-1:0]   req;
  logic                done;
  logic                grant_valid;
  logic [inputLen-1:0] grant_idx;
  logic [numReq-1:0]   grant_onehot;
  logic                timeout;

  typedef struct {
    int idx;
    int dur;
    int to;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  bus_rr_arbiter #(
    .inputLen(inputLen),
    .maxHold (maxHold)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .done        (done),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .grant_onehot(grant_onehot),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edge_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input int idx, input int dur, input int to);
    exp_t e;
    e.idx = idx;
    e.dur = dur;
    e.to  = to;
    q.push_back(e);
  endtask

  // Monitor: measures each grant window and compares it with the scoreboard.
  logic        prev_v = 1'b0;
  int          cur_idx = 0;
  int          cur_dur = 0;
  logic [7:0]  oh_exp;
  exp_t        e_pop;

  always @(negedge clk) begin
    if (grant_valid) begin
      oh_exp = 8'd1 << grant_idx;
      check("onehot_match", grant_onehot, oh_exp);
      check("timeout_in_grant", timeout, 0);
      if (!prev_v) begin
        cur_idx = grant_idx;
        cur_dur = 1;
      end else begin
        cur_dur++;
        check("idx_stable", grant_idx, cur_idx);
      end
    end else begin
      check("onehot_idle", grant_onehot, 0);
      if (prev_v) begin
        if (q.size() == 0) begin
          check("unexpected_grant", cur_idx, 32'hFFFF_FFFF);
        end else begin
          e_pop = q.pop_front();
          check("grant_idx", cur_idx, e_pop.idx);
          check("grant_len", cur_dur, e_pop.dur);
          check("timeout", timeout, e_pop.to);
        end
      end else begin
        check("timeout_stray", timeout, 0);
      end
    end
    prev_v = grant_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    done  = 1'b0;
    #1;
    check("rst_valid", grant_valid, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_onehot", grant_onehot, 0);
    check("rst_timeout", timeout, 0);
    edge_n(2);
    reset = 1'b0;

    // Single requester 2, done in its third grant cycle.
    edge_n(1);
    req = 8'b0000_0100;
    expect_grant(2, 3, 0);
    edge_n(1);
    edge_n(2);
    done = 1'b1;
    edge_n(1);
    done = 1'b0;
    req  = '0;
    edge_n(2);

    // Fresh reset so the rotation starts from index 0.
    reset = 1'b1;
    edge_n(1);
    reset = 1'b0;

    // All requesting, each owner releases with done after two cycles.
    req = 8'hFF;
    for (int k = 0; k < 9; k++) expect_grant(k % 8, 2, 0);
    for (int k = 0; k < 9; k++) begin
      edge_n(1);
      edge_n(1);
      done = 1'b1;
      edge_n(1);
      done = 1'b0;
    end

    // Pointer is now 1: 7 is next, then wrap to 0.
    req = 8'b1000_0001;
    expect_grant(7, 1, 0);
    expect_grant(0, 1, 0);
    for (int k = 0; k < 2; k++) begin
      edge_n(1);
      done = 1'b1;
      edge_n(1);
      done = 1'b0;
    end

    // Owner 5 runs to the hold limit, then 6 is next.
    req = 8'b0110_0000;
    expect_grant(5, 16, 1);
    edge_n(1);
    edge_n(15);
    edge_n(1);
    expect_grant(6, 1, 0);
    edge_n(1);
    req = 8'b0010_0000;
    edge_n(1);

    // Pointer 7 wraps to 5; done coincides with the last hold cycle.
    expect_grant(5, 16, 0);
    edge_n(1);
    edge_n(15);
    done = 1'b1;
    edge_n(1);
    done = 1'b0;

    // Pointer 6 wraps to 3; owner 3 drops its request.
    req = 8'b0000_1000;
    expect_grant(3, 3, 0);
    edge_n(1);
    edge_n(2);
    req = '0;
    edge_n(1);
    edge_n(2);

    // Asynchronous reset in the middle of a grant to 4.
    req = 8'hFF;
    expect_grant(4, 2, 0);
    edge_n(1);
    edge_n(2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", grant_valid, 0);
    check("arst_idx", grant_idx, 0);
    check("arst_onehot", grant_onehot, 0);
    check("arst_timeout", timeout, 0);
    edge_n(2);
    reset = 1'b0;

    // First grant after reset goes to 0.
    expect_grant(0, 2, 0);
    edge_n(1);
    edge_n(1);
    done = 1'b1;
    edge_n(1);
    done = 1'b0;
    req  = '0;
    edge_n(3);

    check("scoreboard_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
